// File: rtl/neuron_accumulator.sv
// Frame accumulator for unsigned 4-bit products; emits sum, beat count, fire and overflow per frame.
// Optional saturation on overflow is enabled with the NEURON_ACC_SAT_EN macro (default: wrap-around).
module neuron_accumulator #(
    parameter int NUM_INPUTS = 8,
    parameter int ACC_WIDTH  = 8,
    parameter int THRESHOLD  = 16,
    localparam int CNT_W     = $clog2(NUM_INPUTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_product,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_fire,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]     cnt_out_q, cnt_out_d;
    logic                 fire_q, fire_d;
    logic                 ovf_out_q, ovf_out_d;
    logic                 valid_q, valid_d;

    logic [ACC_WIDTH:0]   sum_ext_s;
    logic                 carry_s;
    logic [ACC_WIDTH-1:0] acc_new_s;
    logic [CNT_W-1:0]     cnt_new_s;
    logic                 beat_s;
    logic                 frame_end_s;
    logic                 fire_new_s;

    // Datapath: one-bit-wider add so the carry-out flags overflow.
    always_comb begin
        sum_ext_s = {1'b0, acc_q} + {{(ACC_WIDTH-3){1'b0}}, in_product};
        carry_s   = sum_ext_s[ACC_WIDTH];
`ifdef NEURON_ACC_SAT_EN
        if (carry_s) begin
            acc_new_s = {ACC_WIDTH{1'b1}};
        end else begin
            acc_new_s = sum_ext_s[ACC_WIDTH-1:0];
        end
`else
        acc_new_s = sum_ext_s[ACC_WIDTH-1:0];
`endif
        cnt_new_s   = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        beat_s      = in_valid && (state_q == ST_ACC);
        frame_end_s = beat_s && (in_last || (count_q == CNT_W'(NUM_INPUTS - 1)));
        fire_new_s  = (32'(acc_new_s) >= 32'(THRESHOLD));
    end

    // Next-state and result-capture logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        cnt_out_d = cnt_out_q;
        fire_d    = fire_q;
        ovf_out_d = ovf_out_q;
        valid_d   = valid_q;
        case (state_q)
            ST_ACC: begin
                if (beat_s) begin
                    acc_d   = acc_new_s;
                    count_d = cnt_new_s;
                    ovf_d   = ovf_q | carry_s;
                    if (frame_end_s) begin
                        sum_d     = acc_new_s;
                        cnt_out_d = cnt_new_s;
                        fire_d    = fire_new_s;
                        ovf_out_d = ovf_q | carry_s;
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                // Result held until taken; the handshake cycle accepts no beat.
                if (out_ready) begin
                    acc_d   = {ACC_WIDTH{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= {ACC_WIDTH{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
            sum_q     <= {ACC_WIDTH{1'b0}};
            cnt_out_q <= {CNT_W{1'b0}};
            fire_q    <= 1'b0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            cnt_out_q <= cnt_out_d;
            fire_q    <= fire_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_sum   = sum_q;
    assign out_count = cnt_out_q;
    assign out_fire  = fire_q;
    assign out_ovf   = ovf_out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench: instance A (NUM_INPUTS=4, ACC_WIDTH=8, THRESHOLD=20)
// and instance B (NUM_INPUTS=4, ACC_WIDTH=5, THRESHOLD=16) share one stimulus stream.
module tb_neuron_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_product = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       a_in_ready, a_fire, a_ovf, a_valid;
    logic [7:0] a_sum;
    logic [2:0] a_count;
    logic       b_in_ready, b_fire, b_ovf, b_valid;
    logic [4:0] b_sum;
    logic [2:0] b_count;

    int checks = 0;
    int errors = 0;

`ifdef NEURON_ACC_SAT_EN
    localparam logic [4:0] EXP_B_OVF_SUM  = 5'd31;
    localparam logic       EXP_B_OVF_FIRE = 1'b1;
`else
    localparam logic [4:0] EXP_B_OVF_SUM  = 5'd4;
    localparam logic       EXP_B_OVF_FIRE = 1'b0;
`endif

    always #5 clk = ~clk;

    neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(8), .THRESHOLD(20)) u_a (
        .clk(clk), .rst(rst), .in_product(in_product), .in_valid(in_valid), .in_last(in_last),
        .in_ready(a_in_ready), .out_sum(a_sum), .out_count(a_count), .out_fire(a_fire),
        .out_ovf(a_ovf), .out_valid(a_valid), .out_ready(out_ready)
    );

    neuron_accumulator #(.NUM_INPUTS(4), .ACC_WIDTH(5), .THRESHOLD(16)) u_b (
        .clk(clk), .rst(rst), .in_product(in_product), .in_valid(in_valid), .in_last(in_last),
        .in_ready(b_in_ready), .out_sum(b_sum), .out_count(b_count), .out_fire(b_fire),
        .out_ovf(b_ovf), .out_valid(b_valid), .out_ready(out_ready)
    );

    task automatic send_beat(input logic [3:0] p, input logic l);
        @(negedge clk);
        in_product = p;
        in_valid   = 1'b1;
        in_last    = l;
    endtask

    task automatic idle();
        @(negedge clk);
        in_product = 4'd0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", a_valid); end
        checks++; if (a_sum !== 8'd0 || a_count !== 3'd0) begin errors++; $display("FAIL reset_sum_count got %0d/%0d exp 0/0", a_sum, a_count); end
        checks++; if (a_fire !== 1'b0 || a_ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b/%0b exp 0/0", a_fire, a_ovf); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b/%0b exp 1/1", a_in_ready, b_in_ready); end
    endtask

    task automatic test_auto_close();
        send_beat(4'd9, 1'b0);
        send_beat(4'd6, 1'b0);
        send_beat(4'd4, 1'b0);
        send_beat(4'd1, 1'b0);
        idle();
        checks++; if (a_valid !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL auto_valid_ready got %0b/%0b exp 1/0", a_valid, a_in_ready); end
        checks++; if (a_sum !== 8'd20 || a_count !== 3'd4) begin errors++; $display("FAIL auto_sum_count got %0d/%0d exp 20/4", a_sum, a_count); end
        checks++; if (a_fire !== 1'b1 || a_ovf !== 1'b0) begin errors++; $display("FAIL auto_fire_ovf got %0b/%0b exp 1/0", a_fire, a_ovf); end
        checks++; if (b_sum !== 5'd20 || b_fire !== 1'b1 || b_ovf !== 1'b0) begin errors++; $display("FAIL auto_b got %0d/%0b/%0b exp 20/1/0", b_sum, b_fire, b_ovf); end
        release_result();
        checks++; if (a_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL auto_release got %0b/%0b exp 0/1", a_valid, a_in_ready); end
    endtask

    task automatic test_in_last();
        send_beat(4'd3, 1'b0);
        send_beat(4'd2, 1'b1);
        idle();
        checks++; if (a_valid !== 1'b1 || a_sum !== 8'd5 || a_count !== 3'd2 || a_fire !== 1'b0) begin
            errors++; $display("FAIL last_two got v%0b %0d/%0d/%0b exp v1 5/2/0", a_valid, a_sum, a_count, a_fire); end
        release_result();
        send_beat(4'd7, 1'b1);
        idle();
        checks++; if (a_valid !== 1'b1 || a_sum !== 8'd7 || a_count !== 3'd1) begin
            errors++; $display("FAIL last_one got v%0b %0d/%0d exp v1 7/1", a_valid, a_sum, a_count); end
        checks++; if (b_sum !== 5'd7 || b_count !== 3'd1 || b_fire !== 1'b0) begin
            errors++; $display("FAIL last_one_b got %0d/%0d/%0b exp 7/1/0", b_sum, b_count, b_fire); end
        release_result();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) send_beat(4'd9, 1'b0);
        idle();
        checks++; if (a_sum !== 8'd36 || a_ovf !== 1'b0 || a_fire !== 1'b1) begin
            errors++; $display("FAIL ovf_a got %0d/%0b/%0b exp 36/0/1", a_sum, a_ovf, a_fire); end
        checks++; if (b_valid !== 1'b1 || b_sum !== EXP_B_OVF_SUM || b_count !== 3'd4) begin
            errors++; $display("FAIL ovf_b_sum got v%0b %0d/%0d exp v1 %0d/4", b_valid, b_sum, b_count, EXP_B_OVF_SUM); end
        checks++; if (b_ovf !== 1'b1 || b_fire !== EXP_B_OVF_FIRE) begin
            errors++; $display("FAIL ovf_b_flags got %0b/%0b exp 1/%0b", b_ovf, b_fire, EXP_B_OVF_FIRE); end
        release_result();
    endtask

    task automatic test_hold();
        send_beat(4'd2, 1'b0);
        send_beat(4'd2, 1'b1);
        @(negedge clk);
        in_product = 4'd5;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_valid !== 1'b1 || a_sum !== 8'd4 || a_count !== 3'd2 || a_in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_%0d got v%0b %0d/%0d r%0b exp v1 4/2 r0", i, a_valid, a_sum, a_count, a_in_ready); end
            @(negedge clk);
        end
        release_result();
        checks++; if (a_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release got %0b/%0b exp 0/1", a_valid, a_in_ready); end
        idle();
        checks++; if (a_valid !== 1'b1 || a_sum !== 8'd5 || a_count !== 3'd1) begin
            errors++; $display("FAIL hold_next got v%0b %0d/%0d exp v1 5/1", a_valid, a_sum, a_count); end
        release_result();
    endtask

    task automatic test_async_reset();
        send_beat(4'd9, 1'b0);
        send_beat(4'd9, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_valid !== 1'b0 || a_sum !== 8'd0 || a_count !== 3'd0) begin
            errors++; $display("FAIL rst_mid_frame got v%0b %0d/%0d exp v0 0/0", a_valid, a_sum, a_count); end
        idle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(4'd1, 1'b0);
        idle();
        checks++; if (a_valid !== 1'b1 || a_sum !== 8'd4 || a_count !== 3'd4) begin
            errors++; $display("FAIL rst_next_frame got v%0b %0d/%0d exp v1 4/4", a_valid, a_sum, a_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_valid !== 1'b0 || a_sum !== 8'd0 || b_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_hold got v%0b %0d vb%0b exp v0 0 vb0", a_valid, a_sum, b_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
            errors++; $display("FAIL rst_after_hold got r%0b v%0b exp r1 v0", a_in_ready, a_valid); end
    endtask

    task automatic test_gaps();
        logic [3:0] vals [4];
        vals[0] = 4'd4; vals[1] = 4'd0; vals[2] = 4'd9; vals[3] = 4'd2;
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle();
            send_beat(vals[i], 1'b0);
        end
        idle();
        checks++; if (b_valid !== 1'b1 || b_sum !== 5'd15 || b_count !== 3'd4) begin
            errors++; $display("FAIL gaps_b got v%0b %0d/%0d exp v1 15/4", b_valid, b_sum, b_count); end
        checks++; if (b_fire !== 1'b0 || b_ovf !== 1'b0 || a_sum !== 8'd15) begin
            errors++; $display("FAIL gaps_flags got %0b/%0b a%0d exp 0/0 a15", b_fire, b_ovf, a_sum); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_auto_close();
        test_in_last();
        test_overflow();
        test_hold();
        test_async_reset();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Downstream consumer of the 2-bit multiplier array in the neuron datapath.
- Accepts one unsigned 4-bit product per beat over a valid/ready handshake and accumulates a frame of up to NUM_INPUTS products.
- At frame end, presents the sum, beat count, threshold-fire flag and overflow flag on a valid/ready output port.
- The next layer or activation stage consumes these results.

Parameters:
- NUM_INPUTS, 8, maximum products per frame; frame closes automatically after this many beats.
- ACC_WIDTH, 8, accumulator and out_sum width in bits; must be >= 4.
- THRESHOLD, 16, fire threshold; out_fire = (out_sum >= THRESHOLD).
- CNT_W (localparam, derived), $clog2(NUM_INPUTS+1), width of the beat counter and out_count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_product  input  4  unsigned product from the multiplier stage.
- in_valid  input  1  in_product is valid this cycle.
- in_last  input  1  qualified by in_valid; marks the final beat of the frame.
- in_ready  output  1  accumulator can accept a beat.
- out_sum  output  ACC_WIDTH  frame sum.
- out_count  output  CNT_W  number of beats in the frame.
- out_fire  output  1  out_sum >= THRESHOLD.
- out_ovf  output  1  the accumulator exceeded 2^ACC_WIDTH-1 during the frame.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- FSM has two states, ACC and DONE. Reset state is ACC.
- Reset values: acc=0, count=0, out_sum=0, out_count=0, out_fire=0, out_ovf=0, out_valid=0. in_ready=1 once rst deasserts.
- Reset is asynchronous and can occur mid-frame or mid-hold. All partial state is discarded and no result is emitted.
- ACC state:
  - in_ready=1 and out_valid=0.
  - A beat is accepted on in_valid && in_ready: acc <= acc + zero-extended in_product, and count <= count+1.
  - Cycles with in_valid=0 leave the state unchanged.
- Frame end is the accepted beat with in_last=1 or with count==NUM_INPUTS-1, whichever comes first.
  - On frame end, the final sum, count, fire and ovf are registered to the outputs and the FSM moves to DONE.
  - out_valid rises on the cycle after the final beat is accepted (latency 1).
- DONE state:
  - in_ready=0, and in_valid is ignored.
  - Outputs stay stable while out_ready=0.
  - On out_valid && out_ready, acc, count and the ovf tracker clear, out_valid drops the next cycle, and the FSM returns to ACC.
  - No new beat is accepted in the handshake cycle, so the minimum frame period is frame length + 1 cycles.
- Overflow: the add is computed ACC_WIDTH+1 bits wide. A carry-out sets a sticky per-frame ovf bit. Without the optional feature, acc keeps the low ACC_WIDTH bits (wraps).
- in_last on the first beat gives a 1-beat frame: out_count=1 and out_sum=in_product.
- in_product=0 beats still count.
- out_fire is registered, computed from the final sum.

Optional Feature:
- Macro: NEURON_ACC_SAT_EN.
- Defined: on carry-out, acc clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the frame. out_ovf is still set.
- Undefined: wrap-around behaviour as described above.

Test Plan:
- NUM_INPUTS=4, THRESHOLD=20: beats 9,6,4,1 with no in_last -> one cycle after the 4th accept, out_valid=1, out_sum=20, out_count=4, out_fire=1, out_ovf=0, in_ready=0.
- Beats 3, then 2 with in_last=1 -> out_sum=5, out_count=2, out_fire=0. Beat 7 with in_last on the first beat of the next frame -> out_sum=7, out_count=1.
- ACC_WIDTH=5, NUM_INPUTS=4: beats 9,9,9,9 -> without macro out_sum=4, out_ovf=1; with NEURON_ACC_SAT_EN out_sum=31, out_ovf=1.
- Hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 -> outputs constant, in_ready=0, nothing accumulated. Raise out_ready -> out_valid=0 and in_ready=1 next cycle, and the next frame starts from acc=0.
- Assert rst asynchronously (mid-cycle) after 2 of 4 beats (values 9,9) -> outputs zero immediately. Then beats 1,1,1,1 -> out_sum=4, out_count=4.
- Random in_valid gaps, beats 4,0,9,2 -> gaps ignored, out_sum=15, out_count=4, out_fire=0 at THRESHOLD=16.
